// File: rtl/cache_fill_fifo.sv
// Circular staging buffer between the host word stream and the cache fill path.
// Words are popped one at a time through a two-state read FSM with a registered RAM read.
module cache_fill_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_req,
  input  logic              cache_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              drain_done,
  output logic              overflow,
  output logic [AW:0]       level
);

  typedef enum logic {IDLE, FETCH} state_t;

  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       level_q, level_d;
  logic              rd_valid_q, drain_done_q, overflow_q;
  state_t            state_q;

  logic wr_accept, issue, pop;

  assign wr_ready  = (level_q < LVL_FULL);
  assign wr_accept = wr_en & wr_ready & ~flush & ~rst;
  // The empty check deliberately uses the registered level: a same-cycle write is not visible.
  assign issue     = (state_q == IDLE) & rd_req & cache_valid & (level_q != '0);
  assign pop       = (state_q == FETCH);

  always_comb begin
    level_d = level_q;
    case ({wr_accept, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  // Storage: one write port, one registered read port, no reset so it maps to block RAM.
  always_ff @(posedge clk) begin
    if (wr_accept)
      mem[wr_ptr_q] <= wr_data;
    if (issue)
      ram_q <= mem[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      state_q      <= IDLE;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      drain_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else if (flush) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      state_q      <= IDLE;
      rd_valid_q   <= 1'b0;
      drain_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      level_q    <= level_d;
      if (wr_accept)
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (wr_en && !wr_ready)
        overflow_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (rd_req && cache_valid) begin
            if (level_q != '0)
              state_q <= FETCH;
            else
              drain_done_q <= 1'b1;
          end
        end
        FETCH: begin
          rd_data_q  <= ram_q;
          rd_valid_q <= 1'b1;
          rd_ptr_q   <= rd_ptr_q + PTR_ONE;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      // A word arriving means the buffer is no longer drained, even if emptiness was seen this edge.
      if (wr_accept)
        drain_done_q <= 1'b0;
    end
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign drain_done = drain_done_q;
  assign overflow   = overflow_q;
  assign level      = level_q;

endmodule

// File: tb/tb_cache_fill_fifo.sv
// Bench for cache_fill_fifo (DEPTH=4): vector table, corner-case sequences and
// randomized traffic, all checked against a queue-based reference model.
module tb_cache_fill_fifo;
  localparam int DW  = 32;
  localparam int DEP = 4;
  localparam int AW  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0, flush = 1'b0, wr_en = 1'b0, rd_req = 1'b0, cache_valid = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready, rd_valid, drain_done, overflow;
  logic [DW-1:0] rd_data;
  logic [AW:0]   level;

  cache_fill_fifo #(.DATA_W(DW), .DEPTH(DEP)) dut (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .wr_ready(wr_ready), .rd_req(rd_req), .cache_valid(cache_valid),
    .rd_data(rd_data), .rd_valid(rd_valid), .drain_done(drain_done),
    .overflow(overflow), .level(level)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: the buffer is a queue; a pending read delivers the head one edge later.
  logic [DW-1:0] mq[$];
  bit            m_pend, m_valid, m_drain, m_ovf;
  logic [DW-1:0] m_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int n;
    if (rst) begin
      mq.delete(); m_pend = 0; m_valid = 0; m_drain = 0; m_ovf = 0; m_data = '0;
    end else if (flush) begin
      mq.delete(); m_pend = 0; m_valid = 0; m_drain = 0; m_ovf = 0;
    end else begin
      n = mq.size();
      m_valid = 0;
      if (m_pend) begin
        m_data = mq.pop_front();
        m_valid = 1;
        m_pend = 0;
      end else if (rd_req && cache_valid) begin
        if (n != 0) m_pend = 1;
        else m_drain = 1;
      end
      if (wr_en) begin
        if (n < DEP) begin
          mq.push_back(wr_data);
          m_drain = 0;
        end else begin
          m_ovf = 1;
        end
      end
    end
  endtask

  task automatic step(input bit r, input bit f, input bit w, input logic [DW-1:0] d,
                      input bit rq, input bit cv);
    rst = r; flush = f; wr_en = w; wr_data = d; rd_req = rq; cache_valid = cv;
    @(posedge clk);
    model_edge();
    #1;
    chk("rd_valid", 64'(rd_valid), 64'(m_valid));
    chk("rd_data", 64'(rd_data), 64'(m_data));
    chk("level", 64'(level), 64'(mq.size()));
    chk("wr_ready", 64'(wr_ready), 64'(mq.size() < DEP));
    chk("drain_done", 64'(drain_done), 64'(m_drain));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    $display("cyc rst=%0b fl=%0b wr=%0b d=%0h rq=%0b cv=%0b | vld=%0b dat=%0h lvl=%0d rdy=%0b dd=%0b ov=%0b",
             r, f, w, d, rq, cv, rd_valid, rd_data, level, wr_ready, drain_done, overflow);
  endtask

  typedef struct {
    bit            wr;
    logic [DW-1:0] d;
    bit            rd;
    bit            e_valid;
    logic [DW-1:0] e_data;
    int            e_level;
    bit            e_drain;
    bit            e_ovf;
  } vec_t;

  vec_t vt[25];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Three words drained back-to-back, then the overflow scenario (4 accepted, 5th dropped).
    vt[0]  = '{1, 32'hA, 0, 0, 32'h0, 1, 0, 0};
    vt[1]  = '{1, 32'hB, 0, 0, 32'h0, 2, 0, 0};
    vt[2]  = '{1, 32'hC, 0, 0, 32'h0, 3, 0, 0};
    vt[3]  = '{0, 32'h0, 1, 0, 32'h0, 3, 0, 0};
    vt[4]  = '{0, 32'h0, 1, 1, 32'hA, 2, 0, 0};
    vt[5]  = '{0, 32'h0, 1, 0, 32'hA, 2, 0, 0};
    vt[6]  = '{0, 32'h0, 1, 1, 32'hB, 1, 0, 0};
    vt[7]  = '{0, 32'h0, 1, 0, 32'hB, 1, 0, 0};
    vt[8]  = '{0, 32'h0, 1, 1, 32'hC, 0, 0, 0};
    vt[9]  = '{0, 32'h0, 1, 0, 32'hC, 0, 1, 0};
    vt[10] = '{0, 32'h0, 0, 0, 32'hC, 0, 1, 0};
    vt[11] = '{1, 32'h1, 0, 0, 32'hC, 1, 0, 0};
    vt[12] = '{1, 32'h2, 0, 0, 32'hC, 2, 0, 0};
    vt[13] = '{1, 32'h3, 0, 0, 32'hC, 3, 0, 0};
    vt[14] = '{1, 32'h4, 0, 0, 32'hC, 4, 0, 0};
    vt[15] = '{1, 32'h5, 0, 0, 32'hC, 4, 0, 1};
    vt[16] = '{0, 32'h0, 1, 0, 32'hC, 4, 0, 1};
    vt[17] = '{0, 32'h0, 1, 1, 32'h1, 3, 0, 1};
    vt[18] = '{0, 32'h0, 1, 0, 32'h1, 3, 0, 1};
    vt[19] = '{0, 32'h0, 1, 1, 32'h2, 2, 0, 1};
    vt[20] = '{0, 32'h0, 1, 0, 32'h2, 2, 0, 1};
    vt[21] = '{0, 32'h0, 1, 1, 32'h3, 1, 0, 1};
    vt[22] = '{0, 32'h0, 1, 0, 32'h3, 1, 0, 1};
    vt[23] = '{0, 32'h0, 1, 1, 32'h4, 0, 0, 1};
    vt[24] = '{0, 32'h0, 1, 0, 32'h4, 0, 1, 1};

    step(1, 0, 0, 0, 0, 0);
    chk("reset_level", 64'(level), 64'd0);
    chk("reset_ready", 64'(wr_ready), 64'd1);
    chk("reset_data", 64'(rd_data), 64'd0);

    for (int i = 0; i < 25; i++) begin
      step(0, 0, vt[i].wr, vt[i].d, vt[i].rd, vt[i].rd);
      chk("vec_valid", 64'(rd_valid), 64'(vt[i].e_valid));
      chk("vec_data", 64'(rd_data), 64'(vt[i].e_data));
      chk("vec_level", 64'(level), 64'(vt[i].e_level));
      chk("vec_ready", 64'(wr_ready), 64'(vt[i].e_level < DEP));
      chk("vec_drain", 64'(drain_done), 64'(vt[i].e_drain));
      chk("vec_ovf", 64'(overflow), 64'(vt[i].e_ovf));
    end

    // Stall: rd_req held with cache_valid low, then raised.
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h21, 0, 0);
    step(0, 0, 1, 32'h22, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 1, 0);
      chk("stall_no_valid", 64'(rd_valid), 64'd0);
    end
    step(0, 0, 0, 0, 1, 1);
    chk("stall_first_edge", 64'(rd_valid), 64'd0);
    step(0, 0, 0, 0, 1, 1);
    chk("stall_valid", 64'(rd_valid), 64'd1);
    chk("stall_data", 64'(rd_data), 64'h21);

    // Write on the same edge as the pop at level 2.
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h31, 0, 0);
    step(0, 0, 1, 32'h32, 0, 0);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 1, 32'h33, 1, 1);
    chk("same_edge_level", 64'(level), 64'd2);
    chk("same_edge_data", 64'(rd_data), 64'h31);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    chk("same_edge_second", 64'(rd_data), 64'h32);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    chk("same_edge_third", 64'(rd_data), 64'h33);

    // Abort a read in FETCH at level 3 with overflow set: first by flush, then by rst.
    for (int k = 0; k < 2; k++) begin
      step(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 1, 32'h41 + i, 0, 0);
      step(0, 0, 0, 0, 1, 1);
      step(0, 0, 0, 0, 1, 1);
      chk("abort_pre_data", 64'(rd_data), 64'h41);
      step(0, 0, 0, 0, 1, 1);
      chk("abort_pre_level", 64'(level), 64'd3);
      step(k == 1, k == 0, 0, 0, 1, 1);
      chk("abort_level", 64'(level), 64'd0);
      chk("abort_ovf", 64'(overflow), 64'd0);
      chk("abort_drain", 64'(drain_done), 64'd0);
      chk("abort_data", 64'(rd_data), (k == 1) ? 64'd0 : 64'h41);
      step(0, 0, 0, 0, 0, 0);
      chk("abort_no_valid", 64'(rd_valid), 64'd0);
    end

    // Randomized traffic, alternating fill-heavy and drain-heavy phases.
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 800; i++) begin
      bit fill;
      fill = ((i / 50) % 2) == 0;
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 99) < 2),
           ($urandom_range(0, 99) < (fill ? 75 : 30)),
           $urandom(),
           ($urandom_range(0, 99) < (fill ? 40 : 85)),
           ($urandom_range(0, 99) < 75));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
